// File: rtl/data_sram_responder.sv
// data_sram_responder
// Responder end of the EX-stage data SRAM request interface. It holds a
// word-organised data memory that takes byte-lane writes and answers each
// request after WAIT_CYCLES wait states. While a request is outstanding it
// raises stallreq_for_mem so the pipeline keeps the request stable.
//
// Parameters:
//   ADDR_W      word-index bits (depth = 2**ADDR_W 32-bit words)
//   WAIT_CYCLES extra cycles before a response (0 = plain 1-cycle sync RAM)
//
// Ports:
//   clk              rising-edge clock
//   resetn           asynchronous active-low reset (memory is not cleared)
//   data_sram_en     request valid
//   data_sram_wen    byte write enables, 4'b0000 = load
//   data_sram_addr   byte address, word index = addr[ADDR_W+1:2]
//   data_sram_wdata  store data, already lane-replicated by the requester
//   data_sram_rdata  registered read data (pre-write word), held between responses
//   resp_valid       one-cycle pulse when a load or store completes
//   stallreq_for_mem stall request to the pipeline controller
//   addr_err         misaligned-access flag, pulses with resp_valid
//
// Optional feature macro: DSRAM_MISALIGN_CHECK_EN
//   When defined, illegal (wen, addr[1:0]) pairs suppress the write and raise
//   addr_err. When undefined, addr_err is 0 and wen is applied verbatim.
module data_sram_responder #(
    parameter int ADDR_W      = 12,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        resp_valid,
    output logic        stallreq_for_mem,
    output logic        addr_err
);

    localparam int DEPTH = 1 << ADDR_W;

    // The operation that is committed at the "commit" edge: the write lands
    // and the pre-write word is loaded into the read register.
    logic              commit;
    logic [ADDR_W+1:0] op_addr;
    logic [3:0]        op_wen;
    logic [31:0]       op_wdata;
    logic [ADDR_W-1:0] op_idx;
    logic              illegal;
    logic              resp_valid_reg;
    logic              addr_err_reg;

    assign op_idx = op_addr[ADDR_W+1:2];

    // Address bits above the memory depth are ignored by design; the low
    // two bits only matter when the alignment check is built in.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{data_sram_addr[31:ADDR_W+2], op_addr[1:0]};

    generate
        if (WAIT_CYCLES == 0) begin : g_nowait
            // Plain synchronous RAM: every enabled cycle commits immediately.
            assign commit           = data_sram_en;
            assign op_addr          = data_sram_addr[ADDR_W+1:0];
            assign op_wen           = data_sram_wen;
            assign op_wdata         = data_sram_wdata;
            assign stallreq_for_mem = 1'b0;
        end else begin : g_wait
            typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

            localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

            state_t             state_reg, state_next;
            logic [CNT_W-1:0]   cnt_reg, cnt_next;
            logic [ADDR_W+1:0]  addr_reg;
            logic [3:0]         wen_reg;
            logic [31:0]        wdata_reg;
            logic               stall;

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    state_reg <= IDLE;
                    cnt_reg   <= '0;
                    addr_reg  <= '0;
                    wen_reg   <= '0;
                    wdata_reg <= '0;
                end else begin
                    state_reg <= state_next;
                    cnt_reg   <= cnt_next;
                    if (state_reg == IDLE && data_sram_en) begin
                        addr_reg  <= data_sram_addr[ADDR_W+1:0];
                        wen_reg   <= data_sram_wen;
                        wdata_reg <= data_sram_wdata;
                    end
                end
            end

            always_comb begin
                state_next = state_reg;
                cnt_next   = cnt_reg;
                stall      = 1'b0;
                case (state_reg)
                    IDLE: begin
                        if (data_sram_en) begin
                            stall      = 1'b1;
                            cnt_next   = CNT_W'(WAIT_CYCLES - 1);
                            state_next = WAIT;
                        end
                    end
                    WAIT: begin
                        stall = 1'b1;
                        if (cnt_reg == '0) begin
                            state_next = RESP;
                        end else begin
                            cnt_next = cnt_reg - 1'b1;
                        end
                    end
                    RESP: begin
                        // The requester still shows the same request here;
                        // it must not be accepted a second time.
                        state_next = IDLE;
                    end
                    default: state_next = IDLE;
                endcase
            end

            // The edge leaving the last WAIT cycle is the edge entering RESP.
            assign commit           = (state_reg == WAIT) && (cnt_reg == '0);
            assign op_addr          = addr_reg;
            assign op_wen           = wen_reg;
            assign op_wdata         = wdata_reg;
            assign stallreq_for_mem = stall;
        end
    endgenerate

`ifdef DSRAM_MISALIGN_CHECK_EN
    always_comb begin
        illegal = 1'b1;
        case (op_wen)
            4'b1111: illegal = (op_addr[1:0] != 2'd0);
            4'b0011: illegal = (op_addr[1:0] != 2'd0);
            4'b1100: illegal = (op_addr[1:0] != 2'd2);
            4'b0001: illegal = (op_addr[1:0] != 2'd0);
            4'b0010: illegal = (op_addr[1:0] != 2'd1);
            4'b0100: illegal = (op_addr[1:0] != 2'd2);
            4'b1000: illegal = (op_addr[1:0] != 2'd3);
            4'b0000: illegal = 1'b0;
            default: illegal = 1'b1;
        endcase
    end
`else
    assign illegal = 1'b0;
`endif

    // One memory per byte lane so each lane is a simple single-write RAM.
    // The read register samples the old contents in the same edge the write
    // lands, giving read-before-write behaviour.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem [DEPTH];
            logic [7:0] rd_byte_reg;

            always_ff @(posedge clk) begin
                if (commit && op_wen[gi] && !illegal) begin
                    mem[op_idx] <= op_wdata[gi*8 +: 8];
                end
            end

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    rd_byte_reg <= 8'h00;
                end else if (commit) begin
                    rd_byte_reg <= mem[op_idx];
                end
            end

            assign data_sram_rdata[gi*8 +: 8] = rd_byte_reg;
        end
    endgenerate

    // Response flags are high exactly in the cycle after the commit edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            resp_valid_reg <= 1'b0;
            addr_err_reg   <= 1'b0;
        end else begin
            resp_valid_reg <= commit;
            addr_err_reg   <= commit && illegal;
        end
    end

    assign resp_valid = resp_valid_reg;
    assign addr_err   = addr_err_reg;

endmodule

// File: tb/tb_data_sram_responder.sv
// tb_data_sram_responder
// Directed bench for data_sram_responder. Instance u_a uses WAIT_CYCLES=2,
// instance u_b uses WAIT_CYCLES=0. Expected values are hand-computed.
module tb_data_sram_responder;

    logic        clk;
    logic        resetn;

    logic        a_en, b_en;
    logic [3:0]  a_wen, b_wen;
    logic [31:0] a_addr, b_addr, a_wdata, b_wdata;
    logic [31:0] a_rdata, b_rdata;
    logic        a_resp, b_resp, a_stall, b_stall, a_err, b_err;

    int checks = 0;
    int errors = 0;

`ifdef DSRAM_MISALIGN_CHECK_EN
    localparam logic        EXP_MIS_ERR  = 1'b1;
    localparam logic [31:0] EXP_MIS_WORD = 32'h0102_0304;
`else
    localparam logic        EXP_MIS_ERR  = 1'b0;
    localparam logic [31:0] EXP_MIS_WORD = 32'hCAFE_F00D;
`endif

    data_sram_responder #(.ADDR_W(12), .WAIT_CYCLES(2)) u_a (
        .clk(clk), .resetn(resetn),
        .data_sram_en(a_en), .data_sram_wen(a_wen),
        .data_sram_addr(a_addr), .data_sram_wdata(a_wdata),
        .data_sram_rdata(a_rdata), .resp_valid(a_resp),
        .stallreq_for_mem(a_stall), .addr_err(a_err)
    );

    data_sram_responder #(.ADDR_W(12), .WAIT_CYCLES(0)) u_b (
        .clk(clk), .resetn(resetn),
        .data_sram_en(b_en), .data_sram_wen(b_wen),
        .data_sram_addr(b_addr), .data_sram_wdata(b_wdata),
        .data_sram_rdata(b_rdata), .resp_valid(b_resp),
        .stallreq_for_mem(b_stall), .addr_err(b_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One request on u_a, held until its response; en drops on the edge
    // leaving RESP so it is not re-accepted.
    task automatic access_a(input logic [3:0] wen, input logic [31:0] addr,
                            input logic [31:0] wdata, output logic [31:0] rdata,
                            output int stalls, output logic err, output logic got);
        @(posedge clk); #1;
        a_en = 1'b1; a_wen = wen; a_addr = addr; a_wdata = wdata;
        stalls = 0; got = 1'b0; rdata = '0; err = 1'b0;
        for (int c = 0; c < 12 && !got; c++) begin
            @(negedge clk);
            if (a_stall) stalls++;
            if (a_resp) begin
                got = 1'b1; rdata = a_rdata; err = a_err;
            end
        end
        @(posedge clk); #1;
        a_en = 1'b0;
        $display("A wen=%b addr=%h wdata=%h -> rdata=%h stalls=%0d err=%b resp=%b",
                 wen, addr, wdata, rdata, stalls, err, got);
    endtask

    logic [3:0]  bw [8];
    logic [31:0] ba [8], bd [8], be [8];
    logic        bk [8];

    initial begin
        logic [31:0] rd;
        int          st;
        logic        er, got;
        logic [4:0]  resp_pat, stall_pat;

        resetn = 1'b0;
        a_en = 1'b0; a_wen = '0; a_addr = '0; a_wdata = '0;
        b_en = 1'b0; b_wen = '0; b_addr = '0; b_wdata = '0;

        // ---- reset state ----
        repeat (2) @(negedge clk);
        chk("rst_a_rdata", a_rdata, 32'h0);
        chk("rst_a_resp", a_resp, 1'b0);
        chk("rst_a_stall", a_stall, 1'b0);
        chk("rst_a_err", a_err, 1'b0);
        chk("rst_b_rdata", b_rdata, 32'h0);
        chk("rst_b_resp", b_resp, 1'b0);
        @(posedge clk); #1;
        resetn = 1'b1;

        // ---- basic store / load, 3 stall cycles each ----
        access_a(4'b1111, 32'h10, 32'hDEAD_BEEF, rd, st, er, got);
        chk("st10_resp", got, 1'b1);
        chk("st10_stalls", 32'(st), 32'd3);
        chk("st10_err", er, 1'b0);
        access_a(4'b0000, 32'h10, 32'h0, rd, st, er, got);
        chk("ld10_resp", got, 1'b1);
        chk("ld10_stalls", 32'(st), 32'd3);
        chk("ld10_rdata", rd, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("ld10_resp_one_cycle", a_resp, 1'b0);
        chk("ld10_idle_stall", a_stall, 1'b0);

        // ---- byte lanes ----
        access_a(4'b1111, 32'h20, 32'h1122_3344, rd, st, er, got);
        access_a(4'b0100, 32'h22, 32'hAAAA_AAAA, rd, st, er, got);
        chk("byte_st_err", er, 1'b0);
        access_a(4'b0000, 32'h20, 32'h0, rd, st, er, got);
        chk("byte_ld_rdata", rd, 32'h11AA_3344);
        repeat (3) @(negedge clk);
        chk("rdata_hold", a_rdata, 32'h11AA_3344);

        // ---- reset during WAIT of a store ----
        access_a(4'b1111, 32'h30, 32'h1234_5678, rd, st, er, got);
        access_a(4'b0000, 32'h10, 32'h0, rd, st, er, got);
        chk("pre_rst_rdata", rd, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        a_en = 1'b1; a_wen = 4'b1111; a_addr = 32'h30; a_wdata = 32'h0000_0055;
        @(posedge clk); #2;
        chk("mid_wait_stall", a_stall, 1'b1);
        resetn = 1'b0; a_en = 1'b0;
        #1;
        chk("mid_rst_rdata", a_rdata, 32'h0);
        chk("mid_rst_resp", a_resp, 1'b0);
        chk("mid_rst_stall", a_stall, 1'b0);
        chk("mid_rst_err", a_err, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        $display("A reset asserted during WAIT of store addr=00000030");
        access_a(4'b0000, 32'h30, 32'h0, rd, st, er, got);
        chk("post_rst_ld30", rd, 32'h1234_5678);

        // ---- request held through RESP ----
        @(posedge clk); #1;
        a_en = 1'b1; a_wen = 4'b0000; a_addr = 32'h10; a_wdata = 32'h0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            resp_pat[i]  = a_resp;
            stall_pat[i] = a_stall;
        end
        @(posedge clk); #1;
        a_en = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 12 && !got; c++) begin
            @(negedge clk);
            if (a_resp) got = 1'b1;
        end
        $display("A held load addr=00000010 resp_pat=%b stall_pat=%b second_resp=%b",
                 resp_pat, stall_pat, got);
        chk("held_resp_pat", 32'(resp_pat), 32'b01000);
        chk("held_stall_pat", 32'(stall_pat), 32'b10111);
        chk("held_second_resp", got, 1'b1);
        chk("held_second_rdata", a_rdata, 32'hDEAD_BEEF);

        // ---- misaligned store ----
        access_a(4'b1111, 32'h40, 32'h0102_0304, rd, st, er, got);
        chk("al40_err", er, 1'b0);
        access_a(4'b1111, 32'h41, 32'hCAFE_F00D, rd, st, er, got);
        chk("mis41_resp", got, 1'b1);
        chk("mis41_err", er, EXP_MIS_ERR);
        access_a(4'b0000, 32'h40, 32'h0, rd, st, er, got);
        chk("mis41_word40", rd, EXP_MIS_WORD);
        chk("mis41_ld_err", er, 1'b0);

        // ---- WAIT_CYCLES=0: alternating store/load every cycle ----
        bw[0] = 4'b1111; ba[0] = 32'h0; bd[0] = 32'h1111_1111; bk[0] = 1'b0; be[0] = 32'h0;
        bw[1] = 4'b0000; ba[1] = 32'h0; bd[1] = 32'h0;         bk[1] = 1'b1; be[1] = 32'h1111_1111;
        bw[2] = 4'b1111; ba[2] = 32'h4; bd[2] = 32'h2222_2222; bk[2] = 1'b0; be[2] = 32'h0;
        bw[3] = 4'b0000; ba[3] = 32'h4; bd[3] = 32'h0;         bk[3] = 1'b1; be[3] = 32'h2222_2222;
        bw[4] = 4'b1111; ba[4] = 32'h0; bd[4] = 32'h3333_3333; bk[4] = 1'b1; be[4] = 32'h1111_1111;
        bw[5] = 4'b0000; ba[5] = 32'h0; bd[5] = 32'h0;         bk[5] = 1'b1; be[5] = 32'h3333_3333;
        bw[6] = 4'b0001; ba[6] = 32'h4; bd[6] = 32'h4444_4444; bk[6] = 1'b1; be[6] = 32'h2222_2222;
        bw[7] = 4'b0000; ba[7] = 32'h4; bd[7] = 32'h0;         bk[7] = 1'b1; be[7] = 32'h2222_2244;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            b_en = 1'b1; b_wen = bw[k]; b_addr = ba[k]; b_wdata = bd[k];
            @(negedge clk);
            chk("b_stall", b_stall, 1'b0);
            if (k > 0) begin
                $display("B k=%0d wen=%b addr=%h -> rdata=%h resp=%b",
                         k - 1, bw[k-1], ba[k-1], b_rdata, b_resp);
                chk("b_resp", b_resp, 1'b1);
                if (bk[k-1]) chk("b_rdata", b_rdata, be[k-1]);
            end
        end
        @(posedge clk); #1;
        b_en = 1'b0;
        @(negedge clk);
        $display("B k=7 wen=%b addr=%h -> rdata=%h resp=%b", bw[7], ba[7], b_rdata, b_resp);
        chk("b_last_resp", b_resp, 1'b1);
        chk("b_last_rdata", b_rdata, be[7]);
        @(negedge clk);
        chk("b_idle_resp", b_resp, 1'b0);
        chk("b_idle_stall", b_stall, 1'b0);
        chk("b_err", b_err, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
